cellrv32_bus_arbiter: RTL and testbench
=======================================

// Module: cellrv32_bus_arbiter
// PURPOSE
// - 2:1 processor-internal bus arbiter: port A (CPU data) and port B (CPU instruction fetch) share one device bus.
// - Sits directly upstream of the bus keeper. Drives the addr/rden/wren pulses the keeper monitors.
// - Routes device ack/err back to the port that owns the current access.
// PARAMETERS
// - A_PRIO  1  fixed-priority winner on simultaneous requests: 1=port A, 0=port B
// PORTS
// - clk_i       in   1   global clock
// - rst_i       in   1   global reset, asynchronous, active-high
// - a_addr_i    in   32  port A address, held stable by host until a_ack_o/a_err_o
// - a_wdata_i   in   32  port A write data, held stable like a_addr_i
// - a_ben_i     in   4   port A byte enables
// - a_re_i      in   1   port A read request, single-cycle pulse
// - a_we_i      in   1   port A write request, single-cycle pulse
// - a_rdata_o   out  32  port A read data, valid with a_ack_o, else 0
// - a_ack_o     out  1   port A transfer acknowledge
// - a_err_o     out  1   port A transfer error
// - b_addr_i    in   32  port B address, read-only port, held until b_ack_o/b_err_o
// - b_re_i      in   1   port B read request, single-cycle pulse
// - b_rdata_o   out  32  port B read data, valid with b_ack_o, else 0
// - b_ack_o     out  1   port B transfer acknowledge
// - b_err_o     out  1   port B transfer error
// - p_addr_o    out  32  device bus address, from owner; port A address when idle
// - p_wdata_o   out  32  device write data, port A data when owner is A, else 0
// - p_ben_o     out  4   device byte enables, 4'hF for port B
// - p_re_o      out  1   device read pulse, one cycle per access
// - p_we_o      out  1   device write pulse, one cycle per access
// - p_src_o     out  1   owner of current access: 0=A, 1=B
// - p_rdata_i   in   32  device read data
// - p_ack_i     in   1   device acknowledge
// - p_err_i     in   1   device error; keeper error/timeout is OR-ed in here
// BEHAVIOUR
// - FSM states: IDLE, BUSY_A, BUSY_B. Reset state is IDLE.
// - Reset values: all outputs 0, both request buffers 0, state IDLE.
// - Reset mid-access: abort to IDLE, no ack/err issued. A late p_ack_i after reset is ignored.
// - Request capture:
//   - req_a = a_re_i|a_we_i|buf_a; req_b = b_re_i|buf_b.
//   - A pulse that is not issued in its own cycle sets buf_x. buf_a also stores the rd/wr type.
//   - buf_x clears in the cycle its request is issued.
// - IDLE:
//   - Winner picked combinationally. A alone -> A; B alone -> B; both -> A_PRIO.
//   - Issue is zero latency: p_re_o/p_we_o assert in the same cycle as the request (or buffer).
//   - Next state is BUSY_<winner>. The loser stays buffered.
// - BUSY_x:
//   - p_re_o = p_we_o = 0. p_addr_o/p_wdata_o/p_ben_o/p_src_o are muxed from the owner and held stable.
//   - p_ack_i -> x_ack_o=1 and x_rdata_o=p_rdata_i in the same cycle (combinational), then IDLE.
//   - p_err_i -> x_err_o=1, x_ack_o=0, then IDLE. p_err_i has precedence if both p_ack_i and p_err_i are high.
//   - The non-owner port never sees ack/err/rdata.
// - Back-to-back: a buffered request issues in the first IDLE cycle after completion. Gap = 1 cycle between accesses.
// - A new request from the owner port before its own ack/err is a protocol violation. Behaviour is undefined; bench must not generate it.
// - Device responses arriving in IDLE are dropped.
// CONFIGURATION
// - Macro: CELLRV32_BUS_ARB_ROUND_ROBIN_EN
// - Defined:
//   - On simultaneous req_a & req_b in IDLE, the port that did NOT win the previous arbitration wins.
//   - One "last winner" flop, reset to A, so B wins the first collision.
//   - A_PRIO is ignored.
// - Undefined: fixed priority per A_PRIO. No extra state.
// TESTING
// - Single read A @0xFFFFFE00, device acks 2 cycles later with 0x12345678 -> p_re_o 1 cycle, p_src_o=0, a_ack_o=1 with a_rdata_o=0x12345678, b_* stay 0.
// - Same-cycle a_we_i and b_re_i, A_PRIO=1, both acked after 1 cycle -> A issued first; B issued 1 cycle after a_ack_o; p_src_o=1; b_ack_o on B's ack.
// - B busy, a_re_i pulse arrives 1 cycle later -> buf_a=1; A issued in the first IDLE cycle after b_ack_o; exactly one p_re_o per access.
// - p_err_i (keeper timeout) on A write -> a_err_o=1, a_ack_o=0, b_err_o=0, FSM returns to IDLE.
// - rst_i asserted during BUSY_B, then a stray p_ack_i -> all outputs 0, b_ack_o never asserts, next b_re_i is issued normally.
// - With CELLRV32_BUS_ARB_ROUND_ROBIN_EN, 4 consecutive A+B collisions -> winners B,A,B,A. Without it and A_PRIO=1 -> A wins each collision.

Source files
------------

// File: rtl/cellrv32_bus_arbiter.sv
// 2:1 bus arbiter: port A (CPU data) and port B (CPU fetch) share one device bus, zero-latency issue.
// Optional macro CELLRV32_BUS_ARB_ROUND_ROBIN_EN: alternate the collision winner instead of fixed A_PRIO.
module cellrv32_bus_arbiter #(
    parameter bit A_PRIO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    input  logic [3:0]  a_ben_i,
    input  logic        a_re_i,
    input  logic        a_we_i,
    output logic [31:0] a_rdata_o,
    output logic        a_ack_o,
    output logic        a_err_o,
    input  logic [31:0] b_addr_i,
    input  logic        b_re_i,
    output logic [31:0] b_rdata_o,
    output logic        b_ack_o,
    output logic        b_err_o,
    output logic [31:0] p_addr_o,
    output logic [31:0] p_wdata_o,
    output logic [3:0]  p_ben_o,
    output logic        p_re_o,
    output logic        p_we_o,
    output logic        p_src_o,
    input  logic [31:0] p_rdata_i,
    input  logic        p_ack_i,
    input  logic        p_err_i
);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    state_t state, state_n;
    logic   buf_a, buf_a_we, buf_b;
    logic   req_a, req_b, a_is_we, prefer_a;
    logic   grant_a, grant_b, sel_b;

    assign req_a   = a_re_i | a_we_i | buf_a;
    assign req_b   = b_re_i | buf_b;
    assign a_is_we = buf_a ? buf_a_we : a_we_i;

`ifdef CELLRV32_BUS_ARB_ROUND_ROBIN_EN
    // Winner of the last collision; reset to A so B takes the first one.
    logic last_b;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_b <= 1'b0;
        end else if ((state == IDLE) && req_a && req_b) begin
            last_b <= grant_b;
        end
    end

    assign prefer_a = last_b;
`else
    assign prefer_a = A_PRIO;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            buf_a    <= 1'b0;
            buf_a_we <= 1'b0;
            buf_b    <= 1'b0;
        end else begin
            state <= state_n;
            if (grant_a) begin
                buf_a <= 1'b0;
            end else if (a_re_i | a_we_i) begin
                buf_a    <= 1'b1;
                buf_a_we <= a_we_i;
            end
            if (grant_b) begin
                buf_b <= 1'b0;
            end else if (b_re_i) begin
                buf_b <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        sel_b     = 1'b0;
        p_re_o    = 1'b0;
        p_we_o    = 1'b0;
        a_ack_o   = 1'b0;
        a_err_o   = 1'b0;
        a_rdata_o = 32'h0;
        b_ack_o   = 1'b0;
        b_err_o   = 1'b0;
        b_rdata_o = 32'h0;

        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    grant_a = prefer_a;
                    grant_b = ~prefer_a;
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
                sel_b  = grant_b;
                p_re_o = grant_b | (grant_a & ~a_is_we);
                p_we_o = grant_a & a_is_we;
                if (grant_a) begin
                    state_n = BUSY_A;
                end else if (grant_b) begin
                    state_n = BUSY_B;
                end
            end
            BUSY_A: begin
                // Error wins over a simultaneous acknowledge.
                if (p_err_i) begin
                    a_err_o = 1'b1;
                    state_n = IDLE;
                end else if (p_ack_i) begin
                    a_ack_o   = 1'b1;
                    a_rdata_o = p_rdata_i;
                    state_n   = IDLE;
                end
            end
            BUSY_B: begin
                sel_b = 1'b1;
                if (p_err_i) begin
                    b_err_o = 1'b1;
                    state_n = IDLE;
                end else if (p_ack_i) begin
                    b_ack_o   = 1'b1;
                    b_rdata_o = p_rdata_i;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        p_src_o   = sel_b;
        p_addr_o  = sel_b ? b_addr_i : a_addr_i;
        p_wdata_o = sel_b ? 32'h0 : a_wdata_i;
        p_ben_o   = sel_b ? 4'hF : a_ben_i;
    end

endmodule

// File: tb/tb_cellrv32_bus_arbiter.sv
// Bench for cellrv32_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_cellrv32_bus_arbiter;

    localparam bit A_PRIO = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] a_addr_i = '0, a_wdata_i = '0, b_addr_i = '0, p_rdata_i = '0;
    logic [3:0]  a_ben_i = '0;
    logic        a_re_i = 1'b0, a_we_i = 1'b0, b_re_i = 1'b0, p_ack_i = 1'b0, p_err_i = 1'b0;
    logic [31:0] a_rdata_o, b_rdata_o, p_addr_o, p_wdata_o;
    logic [3:0]  p_ben_o;
    logic        a_ack_o, a_err_o, b_ack_o, b_err_o, p_re_o, p_we_o, p_src_o;

    always #5 clk_i = ~clk_i;

    cellrv32_bus_arbiter #(.A_PRIO(A_PRIO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_ben_i(a_ben_i),
        .a_re_i(a_re_i), .a_we_i(a_we_i),
        .a_rdata_o(a_rdata_o), .a_ack_o(a_ack_o), .a_err_o(a_err_o),
        .b_addr_i(b_addr_i), .b_re_i(b_re_i),
        .b_rdata_o(b_rdata_o), .b_ack_o(b_ack_o), .b_err_o(b_err_o),
        .p_addr_o(p_addr_o), .p_wdata_o(p_wdata_o), .p_ben_o(p_ben_o),
        .p_re_o(p_re_o), .p_we_o(p_we_o), .p_src_o(p_src_o),
        .p_rdata_i(p_rdata_i), .p_ack_i(p_ack_i), .p_err_i(p_err_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending (not yet issued) request per port, one bus transaction in flight.
    bit m_a_pend, m_a_we, m_b_pend, m_busy, m_own_b, m_last_b, m_err;
    int m_cnt;
    int lat_cfg = 1;
    bit err_cfg = 1'b0, stray_en = 1'b0, force_stray = 1'b0;
    logic [31:0] rd_pat = '0, last_a_rdata = '0;
    int b_ack_seen = 0;
    int src_log[$];
    int col_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a_pend = 0; m_a_we = 0; m_b_pend = 0; m_busy = 0;
        m_own_b = 0; m_last_b = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_rdata"}, a_rdata_o, 32'h0);
        chk({tag, "_a_ack"}, 32'(a_ack_o), 32'h0);
        chk({tag, "_a_err"}, 32'(a_err_o), 32'h0);
        chk({tag, "_b_rdata"}, b_rdata_o, 32'h0);
        chk({tag, "_b_ack"}, 32'(b_ack_o), 32'h0);
        chk({tag, "_b_err"}, 32'(b_err_o), 32'h0);
        chk({tag, "_p_addr"}, p_addr_o, 32'h0);
        chk({tag, "_p_wdata"}, p_wdata_o, 32'h0);
        chk({tag, "_p_ben"}, 32'(p_ben_o), 32'h0);
        chk({tag, "_p_re"}, 32'(p_re_o), 32'h0);
        chk({tag, "_p_we"}, 32'(p_we_o), 32'h0);
        chk({tag, "_p_src"}, 32'(p_src_o), 32'h0);
    endtask

    // One clock cycle: host inputs already driven; drive device, check at negedge, advance.
    task automatic tick();
        bit resp, issue, col, win_b, sel_b, ok_a, ok_b;
        p_ack_i = 1'b0; p_err_i = 1'b0; p_rdata_i = rd_pat; resp = 0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt <= 0) begin
                resp = 1;
                if (m_err) begin
                    p_err_i = 1'b1;
                    p_ack_i = ($urandom_range(0, 1) == 1);
                end else begin
                    p_ack_i = 1'b1;
                end
            end
        end else if (force_stray || (stray_en && $urandom_range(0, 3) == 0)) begin
            p_ack_i = 1'b1;
            p_err_i = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk_i);
        if (a_re_i || a_we_i) begin m_a_pend = 1; m_a_we = a_we_i; end
        if (b_re_i) m_b_pend = 1;
        issue = !m_busy && (m_a_pend || m_b_pend);
        col   = issue && m_a_pend && m_b_pend;
        if (col) begin
`ifdef CELLRV32_BUS_ARB_ROUND_ROBIN_EN
            win_b = !m_last_b;
`else
            win_b = !A_PRIO;
`endif
        end else begin
            win_b = m_b_pend;
        end
        sel_b = m_busy ? m_own_b : (issue && win_b);
        ok_a  = resp && !m_own_b && !m_err;
        ok_b  = resp && m_own_b && !m_err;
        chk("p_re", 32'(p_re_o), 32'(issue && (win_b || !m_a_we)));
        chk("p_we", 32'(p_we_o), 32'(issue && !win_b && m_a_we));
        chk("p_src", 32'(p_src_o), 32'(sel_b));
        chk("p_addr", p_addr_o, sel_b ? b_addr_i : a_addr_i);
        chk("p_wdata", p_wdata_o, sel_b ? 32'h0 : a_wdata_i);
        chk("p_ben", 32'(p_ben_o), sel_b ? 32'hF : 32'(a_ben_i));
        chk("a_ack", 32'(a_ack_o), 32'(ok_a));
        chk("a_err", 32'(a_err_o), 32'(resp && !m_own_b && m_err));
        chk("a_rdata", a_rdata_o, ok_a ? rd_pat : 32'h0);
        chk("b_ack", 32'(b_ack_o), 32'(ok_b));
        chk("b_err", 32'(b_err_o), 32'(resp && m_own_b && m_err));
        chk("b_rdata", b_rdata_o, ok_b ? rd_pat : 32'h0);
        if (a_ack_o === 1'b1) last_a_rdata = a_rdata_o;
        if (b_ack_o === 1'b1) b_ack_seen++;
        if (resp) m_busy = 0;
        if (issue) begin
            m_busy  = 1;
            m_own_b = win_b;
            if (win_b) m_b_pend = 0; else m_a_pend = 0;
            m_cnt = lat_cfg;
            m_err = err_cfg;
            src_log.push_back(int'(win_b));
            if (col) begin
                col_log.push_back(int'(win_b));
                m_last_b = win_b;
            end
        end
        @(posedge clk_i); #1;
        a_re_i = 1'b0; a_we_i = 1'b0; b_re_i = 1'b0;
        p_ack_i = 1'b0; p_err_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((m_busy || m_a_pend || m_b_pend) && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(m_busy || m_a_pend || m_b_pend), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_col[4];
        model_reset();
        // Reset values
        rst_i = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Single read on A, device answers two cycles after issue
        a_addr_i = 32'hFFFF_FE00; a_wdata_i = 32'hDEAD_0001; a_ben_i = 4'hF;
        rd_pat = 32'h1234_5678; lat_cfg = 2; src_log.delete();
        a_re_i = 1'b1;
        tick();
        drain(20);
        chk("t1_rdata", last_a_rdata, 32'h1234_5678);
        chk("t1_issues", 32'(src_log.size()), 32'd1);
        chk("t1_src", 32'(src_log[0]), 32'd0);

        // Simultaneous A write and B read
        a_addr_i = 32'h0000_1000; a_wdata_i = 32'hCAFE_F00D; a_ben_i = 4'h3;
        b_addr_i = 32'h0000_2000; rd_pat = 32'hA5A5_0002; lat_cfg = 1; src_log.delete();
        a_we_i = 1'b1; b_re_i = 1'b1;
        tick();
        drain(20);
        chk("t2_issues", 32'(src_log.size()), 32'd2);
`ifdef CELLRV32_BUS_ARB_ROUND_ROBIN_EN
        chk("t2_first", 32'(src_log[0]), 32'd1);
`else
        chk("t2_first", 32'(src_log[0]), A_PRIO ? 32'd0 : 32'd1);
`endif

        // B busy, A arrives one cycle later and waits in its buffer
        b_addr_i = 32'h0000_3000; a_addr_i = 32'h0000_4000; lat_cfg = 3; src_log.delete();
        b_re_i = 1'b1;
        tick();
        a_re_i = 1'b1;
        tick();
        drain(20);
        chk("t3_issues", 32'(src_log.size()), 32'd2);
        chk("t3_order", 32'(src_log[0] * 2 + src_log[1]), 32'd2);

        // Device error on an A write (error may coincide with ack)
        a_addr_i = 32'h0000_5000; a_wdata_i = 32'h1111_2222; err_cfg = 1'b1; lat_cfg = 2;
        a_we_i = 1'b1;
        tick();
        drain(20);
        err_cfg = 1'b0;

        // Reset in the middle of a B access, then a stray device ack
        b_addr_i = 32'h0000_6000; lat_cfg = 6;
        b_re_i = 1'b1;
        tick(); tick(); tick();
        a_addr_i = '0; a_wdata_i = '0; a_ben_i = '0; b_addr_i = '0;
        rst_i = 1'b1;
        #2;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        b_ack_seen = 0;
        force_stray = 1'b1;
        tick();
        force_stray = 1'b0;
        chk("t5_stray_b_ack", 32'(b_ack_seen), 32'd0);
        b_addr_i = 32'h0000_7000; lat_cfg = 1;
        b_re_i = 1'b1;
        tick();
        drain(20);
        chk("t5_b_ack_count", 32'(b_ack_seen), 32'd1);

        // Four back-to-back collisions
        col_log.delete();
        for (int k = 0; k < 4; k++) begin
            a_addr_i = $urandom; a_wdata_i = $urandom; a_ben_i = 4'($urandom);
            b_addr_i = $urandom; lat_cfg = 1;
            a_re_i = 1'b1; b_re_i = 1'b1;
            tick();
            drain(20);
        end
`ifdef CELLRV32_BUS_ARB_ROUND_ROBIN_EN
        exp_col = '{1, 0, 1, 0};
`else
        exp_col = '{0, 0, 0, 0};
`endif
        chk("t6_collisions", 32'(col_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < col_log.size()) chk("t6_winner", 32'(col_log[k]), 32'(exp_col[k]));
        end

        // Random traffic with stray responses in idle
        stray_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            rd_pat  = $urandom;
            lat_cfg = $urandom_range(1, 4);
            err_cfg = ($urandom_range(0, 5) == 0);
            if (!(m_a_pend || (m_busy && !m_own_b)) && $urandom_range(0, 2) == 0) begin
                a_addr_i = $urandom; a_wdata_i = $urandom; a_ben_i = 4'($urandom);
                if ($urandom_range(0, 1) == 1) a_we_i = 1'b1; else a_re_i = 1'b1;
            end
            if (!(m_b_pend || (m_busy && m_own_b)) && $urandom_range(0, 2) == 0) begin
                b_addr_i = $urandom;
                b_re_i = 1'b1;
            end
            tick();
        end
        stray_en = 1'b0;
        err_cfg = 1'b0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
